// File: rtl/signed_divider.sv
// rtl/signed_divider.sv - 32/16 signed sequential divider, radix-2 restoring, 18-cycle latency
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-low reset
//   startDiv  in   1   start request, sampled only in IDLE
//   A         in  32   signed dividend
//   B         in  16   signed divisor
//   busy      out  1   division in progress
//   Q         out 16   signed quotient, truncated toward zero
//   R         out 16   signed remainder, sign follows A
//   readyDiv  out  1   one-cycle result-valid pulse
//   dbz       out  1   divide-by-zero flag
//   ovf       out  1   quotient overflow flag

module signed_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        startDiv,
    input  logic [31:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        readyDiv,
    output logic        dbz,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        SIGN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] abs_b_q, abs_b_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;
    logic        sq_q, sq_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;
    logic [15:0] q_q, q_d;
    logic [15:0] r_q, r_d;

    // Magnitudes of the latched operands. 0x80000000 maps to 2^31, which
    // still fits in 32 unsigned bits; likewise 0x8000 for the divisor.
    logic [31:0] abs_a;
    logic [15:0] abs_b;
    assign abs_a = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b = b_q[15] ? (~b_q + 16'd1) : b_q;

    // Trial subtraction; bit 17 set means the shifted remainder is below |B|.
    logic [17:0] diff;
    assign diff = {1'b0, rem_q, dvd_q[15]} - {2'b00, abs_b_q};

    // Quotient magnitude limit: 32767 for positive, 32768 for negative.
    logic q_too_big;
    assign q_too_big = sq_q ? (quo_q > 16'h8000) : (quo_q > 16'h7FFF);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        abs_b_d = abs_b_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sq_d    = sq_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        q_d     = q_q;
        r_d     = r_q;

        case (state_q)
            IDLE: begin
                if (startDiv) begin
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sa_d    = a_q[31];
                sq_d    = a_q[31] ^ b_q[15];
                abs_b_d = abs_b;
                // Upper half seeds the partial remainder; lower half is
                // shifted in one bit per DIV step.
                rem_d   = abs_a[31:16];
                dvd_d   = abs_a[15:0];
                quo_d   = 16'd0;
                cnt_d   = 4'd0;
                if (b_q == 16'd0) begin
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    q_d     = 16'd0;
                    r_d     = 16'd0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (abs_a[31:16] >= abs_b) begin
                    // Quotient cannot fit in 16 bits.
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    q_d     = 16'd0;
                    r_d     = 16'd0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                dvd_d = {dvd_q[14:0], 1'b0};
                if (!diff[17]) begin
                    rem_d = diff[15:0];
                    quo_d = {quo_q[14:0], 1'b1};
                end else begin
                    rem_d = {rem_q[14:0], dvd_q[15]};
                    quo_d = {quo_q[14:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                dbz_d   = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (q_too_big) begin
                    ovf_d = 1'b1;
                    q_d   = 16'd0;
                    r_d   = 16'd0;
                end else begin
                    ovf_d = 1'b0;
                    q_d   = sq_q ? (~quo_q + 16'd1) : quo_q;
                    r_d   = sa_q ? (~rem_q + 16'd1) : rem_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 16'd0;
            abs_b_q <= 16'd0;
            rem_q   <= 16'd0;
            dvd_q   <= 16'd0;
            quo_q   <= 16'd0;
            cnt_q   <= 4'd0;
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            q_q     <= 16'd0;
            r_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            abs_b_q <= abs_b_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sq_q    <= sq_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign busy     = busy_q;
    assign readyDiv = ready_q;
    assign dbz      = dbz_q;
    assign ovf      = ovf_q;
    assign Q        = q_q;
    assign R        = r_q;

endmodule

// File: tb/tb_signed_divider.sv
// tb/tb_signed_divider.sv - directed-vector self-checking bench for signed_divider

module tb_signed_divider;

    logic        clk;
    logic        rst;
    logic        startDiv;
    logic [31:0] A;
    logic [15:0] B;
    logic        busy;
    logic [15:0] Q;
    logic [15:0] R;
    logic        readyDiv;
    logic        dbz;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    signed_divider dut (
        .clk      (clk),
        .rst      (rst),
        .startDiv (startDiv),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .Q        (Q),
        .R        (R),
        .readyDiv (readyDiv),
        .dbz      (dbz),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents operands with startDiv high and returns #1 after the sampling edge,
    // then scrambles the operand inputs so the result relies on the latched copy.
    task automatic do_start(input string tag, input logic [31:0] a, input logic [15:0] b);
        A        = a;
        B        = b;
        startDiv = 1'b1;
        @(posedge clk);
        #1;
        startDiv = 1'b0;
        A        = $urandom;
        B        = 16'($urandom);
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
    endtask

    // Counts edges until readyDiv, checks latency, busy continuity and results.
    task automatic wait_ready(input string tag, input int exp_lat, input logic [15:0] eq,
                              input logic [15:0] er, input logic edbz, input logic eovf);
        int lat = 0;
        int busy_drop = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (readyDiv) break;
            if (!busy) busy_drop++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_gap"}, 32'(busy_drop), 32'd0);
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".Q"}, 32'(Q), 32'(eq));
        check({tag, ".R"}, 32'(R), 32'(er));
        check({tag, ".dbz"}, 32'(dbz), 32'(edbz));
        check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
    endtask

    // One edge after the result: pulse gone, outputs held.
    task automatic check_hold(input string tag, input logic [15:0] eq, input logic [15:0] er);
        @(posedge clk);
        #1;
        check({tag, ".ready_pulse"}, 32'(readyDiv), 32'd0);
        check({tag, ".Q_hold"}, 32'(Q), 32'(eq));
        check({tag, ".R_hold"}, 32'(R), 32'(er));
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input int lat, input logic [15:0] eq, input logic [15:0] er,
                           input logic edbz, input logic eovf);
        do_start(tag, a, b);
        wait_ready(tag, lat, eq, er, edbz, eovf);
        check_hold(tag, eq, er);
    endtask

    // Counts readyDiv pulses and busy cycles over a window of idle edges.
    task automatic quiet_window(input string tag, input int n);
        int pulses = 0;
        int busies = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (readyDiv) pulses++;
            if (busy) busies++;
        end
        check({tag, ".no_ready"}, 32'(pulses), 32'd0);
        check({tag, ".no_busy"}, 32'(busies), 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        startDiv = 1'b0;
        A        = 32'd0;
        B        = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.ready", 32'(readyDiv), 32'd0);
        check("reset.Q", 32'(Q), 32'd0);
        check("reset.R", 32'(R), 32'd0);
        check("reset.dbz", 32'(dbz), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_vec("neg10_neg17",  32'hFFFF_FFF6, 16'hFFEF, 18, 16'h0000, 16'hFFF6, 1'b0, 1'b0);
        run_vec("p1000_p7",     32'd1000,      16'd7,    18, 16'h008E, 16'h0006, 1'b0, 1'b0);
        run_vec("n1000_p7",     32'hFFFF_FC18, 16'd7,    18, 16'hFF72, 16'hFFFA, 1'b0, 1'b0);
        run_vec("p1000_n7",     32'd1000,      16'hFFF9, 18, 16'hFF72, 16'h0006, 1'b0, 1'b0);
        run_vec("div_zero",     32'd1234,      16'd0,    1,  16'h0000, 16'h0000, 1'b1, 1'b0);
        run_vec("pre_ovf",      32'h7FFF_FFFF, 16'd1,    1,  16'h0000, 16'h0000, 1'b0, 1'b1);
        run_vec("min_by_min",   32'h8000_0000, 16'h8000, 1,  16'h0000, 16'h0000, 1'b0, 1'b1);
        run_vec("p32768_p1",    32'd32768,     16'd1,    18, 16'h0000, 16'h0000, 1'b0, 1'b1);
        run_vec("n32768_p1",    32'hFFFF_8000, 16'd1,    18, 16'h8000, 16'h0000, 1'b0, 1'b0);
        run_vec("p100000_n7",   32'd100000,    16'hFFF9, 18, 16'hC833, 16'h0005, 1'b0, 1'b0);

        // A start pulse five edges into an operation must be ignored.
        do_start("ignore", 32'd1000, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        A        = 32'd5;
        B        = 16'd1;
        startDiv = 1'b1;
        @(posedge clk);
        #1;
        startDiv = 1'b0;
        wait_ready("ignore", 13, 16'h008E, 16'h0006, 1'b0, 1'b0);
        check_hold("ignore", 16'h008E, 16'h0006);
        quiet_window("ignore_after", 25);

        // Reset mid-operation aborts with no result; start is ignored during reset.
        do_start("abort", 32'hFFFF_FC18, 16'd7);
        repeat (9) @(posedge clk);
        #1;
        rst      = 1'b0;
        startDiv = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.ready", 32'(readyDiv), 32'd0);
        check("abort.Q", 32'(Q), 32'd0);
        check("abort.R", 32'(R), 32'd0);
        check("abort.dbz", 32'(dbz), 32'd0);
        check("abort.ovf", 32'(ovf), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort.busy_in_rst", 32'(busy), 32'd0);
        startDiv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        quiet_window("abort_after", 25);
        run_vec("after_abort", 32'd1000, 16'd7, 18, 16'h008E, 16'h0006, 1'b0, 1'b0);

        // Restart in the readyDiv cycle: busy low for exactly that cycle.
        do_start("b2b_first", 32'd1000, 16'd7);
        wait_ready("b2b_first", 18, 16'h008E, 16'h0006, 1'b0, 1'b0);
        A        = 32'hFFFF_FFF6;
        B        = 16'hFFEF;
        startDiv = 1'b1;
        @(posedge clk);
        #1;
        startDiv = 1'b0;
        A        = 32'd0;
        B        = 16'd0;
        check("b2b.busy_restart", 32'(busy), 32'd1);
        check("b2b.ready_gone", 32'(readyDiv), 32'd0);
        wait_ready("b2b_second", 18, 16'h0000, 16'hFFF6, 1'b0, 1'b0);
        check_hold("b2b_second", 16'h0000, 16'hFFF6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
